gpio_acc_arb: RTL and testbench

GPIO_ACC_ARB -- requirements
Module: gpio_acc_arb

---
 rtl/gpio_acc_arb.sv | 162 ++++++++++++++++
 tb/tb_gpio_acc_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_acc_arb.sv
// Two-requester round-robin arbiter in front of a 16-offset GPIO bank.
// B writes to offsets flagged in WP_MASK_B are refused without touching the bank.
//
// state | meaning
// IDLE  | arbitrate, latch winner's request
// ISSUE | single-cycle bank strobe
// CAPT  | bank registers its read data
// DONE  | one-cycle ACK to the granted requester
module gpio_acc_arb #(
  parameter logic [15:0] WP_MASK_B = 16'h0000
) (
  input  logic        sysclk_i,
  input  logic        reset_i,
  input  logic        req_a_i,
  input  logic        rd_wr_a_i,
  input  logic [3:0]  addr_a_i,
  input  logic [7:0]  wdata_a_i,
  input  logic        req_b_i,
  input  logic        rd_wr_b_i,
  input  logic [3:0]  addr_b_i,
  input  logic [7:0]  wdata_b_i,
  output logic        ack_a_o,
  output logic [7:0]  rdata_a_o,
  output logic        ack_b_o,
  output logic [7:0]  rdata_b_o,
  output logic        err_b_o,
  output logic        port_cs_o,
  output logic [15:0] offset_sel_o,
  output logic        rd_wr_o,
  output logic [7:0]  bank_din_o,
  input  logic [7:0]  bank_dout_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;   // 0 = A, 1 = B
  logic        gnt_q, gnt_d;
  logic        rw_q, rw_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        port_cs_q, port_cs_d;
  logic [15:0] offset_q, offset_d;
  logic        rd_wr_q, rd_wr_d;
  logic [7:0]  din_q, din_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic        err_b_q, err_b_d;
  logic [7:0]  rdata_a_q, rdata_a_d;
  logic [7:0]  rdata_b_q, rdata_b_d;

  logic        pick;
  logic        sel_rw;
  logic [3:0]  sel_addr;
  logic [7:0]  sel_wdata;
  logic [15:0] wp_mask;

  assign wp_mask = WP_MASK_B;

  always_comb begin
    pick      = (req_a_i && req_b_i) ? ~last_q : req_b_i;
    sel_rw    = pick ? rd_wr_b_i : rd_wr_a_i;
    sel_addr  = pick ? addr_b_i  : addr_a_i;
    sel_wdata = pick ? wdata_b_i : wdata_a_i;
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    port_cs_d = 1'b0;
    offset_d  = 16'h0000;
    rd_wr_d   = 1'b1;
    din_d     = 8'h00;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    err_b_d   = 1'b0;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    case (state_q)
      IDLE: begin
        if (req_a_i || req_b_i) begin
          gnt_d   = pick;
          last_d  = pick;
          rw_d    = sel_rw;
          wdata_d = sel_wdata;
          if (pick && !sel_rw && wp_mask[sel_addr]) begin
            state_d = DONE;
            ack_b_d = 1'b1;
            err_b_d = 1'b1;
          end else begin
            state_d   = ISSUE;
            port_cs_d = 1'b1;
            offset_d  = 16'h0001 << sel_addr;
            rd_wr_d   = sel_rw;
            din_d     = sel_wdata;
          end
        end
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        state_d = DONE;
        if (gnt_q) begin
          ack_b_d = 1'b1;
          if (rw_q) rdata_b_d = bank_dout_i;
        end else begin
          ack_a_d = 1'b1;
          if (rw_q) rdata_a_d = bank_dout_i;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      rw_q      <= 1'b1;
      wdata_q   <= 8'h00;
      port_cs_q <= 1'b0;
      offset_q  <= 16'h0000;
      rd_wr_q   <= 1'b1;
      din_q     <= 8'h00;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      err_b_q   <= 1'b0;
      rdata_a_q <= 8'h00;
      rdata_b_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      port_cs_q <= port_cs_d;
      offset_q  <= offset_d;
      rd_wr_q   <= rd_wr_d;
      din_q     <= din_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      err_b_q   <= err_b_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign ack_a_o      = ack_a_q;
  assign ack_b_o      = ack_b_q;
  assign err_b_o      = err_b_q;
  assign rdata_a_o    = rdata_a_q;
  assign rdata_b_o    = rdata_b_q;
  assign port_cs_o    = port_cs_q;
  assign offset_sel_o = offset_q;
  assign rd_wr_o      = rd_wr_q;
  assign bank_din_o   = din_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_gpio_acc_arb.sv
// Directed bench for gpio_acc_arb: reset, single accesses, contention,
// write protection and mid-transaction reset abort.
module tb_gpio_acc_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, rw_a, req_b, rw_b;
  logic [3:0]  addr_a, addr_b;
  logic [7:0]  wdata_a, wdata_b, bank_dout;
  logic        ack_a, ack_b, err_b, port_cs, rd_wr, busy;
  logic [7:0]  rdata_a, rdata_b, bank_din;
  logic [15:0] offset_sel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gpio_acc_arb #(.WP_MASK_B(16'h0020)) dut (
    .sysclk_i(clk), .reset_i(rst),
    .req_a_i(req_a), .rd_wr_a_i(rw_a), .addr_a_i(addr_a), .wdata_a_i(wdata_a),
    .req_b_i(req_b), .rd_wr_b_i(rw_b), .addr_b_i(addr_b), .wdata_b_i(wdata_b),
    .ack_a_o(ack_a), .rdata_a_o(rdata_a), .ack_b_o(ack_b), .rdata_b_o(rdata_b),
    .err_b_o(err_b), .port_cs_o(port_cs), .offset_sel_o(offset_sel),
    .rd_wr_o(rd_wr), .bank_din_o(bank_din), .bank_dout_i(bank_dout), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " ack_a"},   ack_a, 0);
    check({tag, " ack_b"},   ack_b, 0);
    check({tag, " err_b"},   err_b, 0);
    check({tag, " port_cs"}, port_cs, 0);
    check({tag, " offset"},  offset_sel, 0);
    check({tag, " din"},     bank_din, 0);
    check({tag, " rdata_a"}, rdata_a, 0);
    check({tag, " rdata_b"}, rdata_b, 0);
    check({tag, " busy"},    busy, 0);
    check({tag, " rd_wr"},   rd_wr, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] exp_ra, exp_rb;
  logic       exp_g;
  logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    rst = 1'b1;
    {req_a, rw_a, req_b, rw_b} = 4'b0101;
    addr_a = 4'h0; addr_b = 4'h0; wdata_a = 8'h00; wdata_b = 8'h00;
    bank_dout = 8'h00;
    #3;
    check_reset_outs("rst_idle");
    tick();
    rst = 1'b0;
    tick();

    // A write to offset 3; inputs changed after grant must not matter
    req_a = 1; rw_a = 0; addr_a = 4'h3; wdata_a = 8'h5A; bank_dout = 8'hEE;
    tick();
    addr_a = 4'h7; wdata_a = 8'h00; rw_a = 1;
    check("aw cs", port_cs, 1);
    check("aw off", offset_sel, 16'h0008);
    check("aw rdwr", rd_wr, 0);
    check("aw din", bank_din, 8'h5A);
    check("aw busy", busy, 1);
    tick();
    check("aw cs1", port_cs, 0);
    check("aw off1", offset_sel, 0);
    check("aw rdwr1", rd_wr, 1);
    check("aw din1", bank_din, 0);
    check("aw ack1", ack_a, 0);
    tick();
    check("aw ack2", ack_a, 1);
    check("aw rdata", rdata_a, 8'h00);
    check("aw ackb", ack_b, 0);
    tick();
    req_a = 0;
    check("aw ack3", ack_a, 0);
    tick();
    check("aw idle", busy, 0);

    // B read from offset F
    req_b = 1; rw_b = 1; addr_b = 4'hF; bank_dout = 8'hC3;
    tick();
    check("br cs", port_cs, 1);
    check("br off", offset_sel, 16'h8000);
    check("br rdwr", rd_wr, 1);
    tick();
    tick();
    check("br ack", ack_b, 1);
    check("br rdata", rdata_b, 8'hC3);
    check("br err", err_b, 0);
    check("br acka", ack_a, 0);
    check("br rdata_a", rdata_a, 8'h00);
    tick();
    req_b = 0;
    check("br ack3", ack_b, 0);
    tick();

    // contention from reset release: expect A,B,A,B
    req_a = 1; rw_a = 1; addr_a = 4'h1;
    req_b = 1; rw_b = 1; addr_b = 4'h2;
    do_reset();
    exp_ra = 8'h00; exp_rb = 8'h00;
    for (int g = 0; g < 4; g++) begin
      exp_g = g[0];
      bank_dout = vals[g];
      tick();
      check($sformatf("ct%0d cs", g), port_cs, 1);
      check($sformatf("ct%0d off", g), offset_sel, exp_g ? 16'h0004 : 16'h0002);
      tick();
      check($sformatf("ct%0d cs1", g), port_cs, 0);
      tick();
      check($sformatf("ct%0d cs2", g), port_cs, 0);
      if (exp_g) exp_rb = vals[g]; else exp_ra = vals[g];
      check($sformatf("ct%0d acka", g), ack_a, !exp_g);
      check($sformatf("ct%0d ackb", g), ack_b, exp_g);
      check($sformatf("ct%0d rda", g), rdata_a, exp_ra);
      check($sformatf("ct%0d rdb", g), rdata_b, exp_rb);
      tick();
      check($sformatf("ct%0d cs3", g), port_cs, 0);
      check($sformatf("ct%0d ack3", g), ack_a | ack_b, 0);
    end
    req_a = 0; req_b = 0;
    tick();
    tick();

    // protected B write to offset 5
    req_b = 1; rw_b = 0; addr_b = 4'h5; wdata_b = 8'h77; bank_dout = 8'h99;
    tick();
    check("wp cs", port_cs, 0);
    check("wp ack", ack_b, 1);
    check("wp err", err_b, 1);
    check("wp rdb", rdata_b, exp_rb);
    check("wp busy", busy, 1);
    tick();
    req_b = 0;
    check("wp ack1", ack_b, 0);
    check("wp err1", err_b, 0);
    check("wp busy1", busy, 0);
    check("wp cs1", port_cs, 0);
    tick();

    // A write to the same offset proceeds normally
    req_a = 1; rw_a = 0; addr_a = 4'h5; wdata_a = 8'h3C;
    tick();
    check("wa cs", port_cs, 1);
    check("wa off", offset_sel, 16'h0020);
    check("wa din", bank_din, 8'h3C);
    check("wa err", err_b, 0);
    tick();
    tick();
    check("wa ack", ack_a, 1);
    check("wa err2", err_b, 0);
    tick();
    req_a = 0;
    tick();

    // unprotected B write goes through the bank
    req_b = 1; rw_b = 0; addr_b = 4'h4; wdata_b = 8'hA5;
    tick();
    check("bw cs", port_cs, 1);
    check("bw off", offset_sel, 16'h0010);
    tick();
    tick();
    check("bw ack", ack_b, 1);
    check("bw err", err_b, 0);
    check("bw rdb", rdata_b, exp_rb);
    tick();
    req_b = 0;
    tick();

    // abort in ISSUE, reset also checked after traffic
    req_a = 1; rw_a = 1; addr_a = 4'h9; bank_dout = 8'h6D;
    tick();
    check("ab cs", port_cs, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outs("rst_abort");
    tick();
    tick();
    check("ab noack", ack_a, 0);
    rst = 1'b0;
    tick();
    check("ab cs2", port_cs, 1);
    check("ab off2", offset_sel, 16'h0200);
    tick();
    check("ab ack1", ack_a, 0);
    tick();
    check("ab ack2", ack_a, 1);
    check("ab rda", rdata_a, 8'h6D);
    tick();
    req_a = 0;
    check("ab ack3", ack_a, 0);
    tick();
    check("ab idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
